// File: rtl/demux1x2_buf_pkg.sv
// Shared definitions for the buffered 1-to-2 demultiplexer.
package demux1x2_buf_pkg;

  // Select encoding on in_sel: which output channel a word is routed to.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Channel identity used when describing routing decisions.
  typedef enum logic {
    CH_A = SEL_A,
    CH_B = SEL_B
  } channel_e;

endpackage

// File: rtl/demux1x2_buf_sync_fifo.sv
// Single-clock FIFO with registered storage and fall-through head output.
// Occupancy is tracked with a separate counter (0..DEPTH) so that the
// pointers can stay log2(DEPTH) bits wide and simply wrap.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when it pops the same cycle.
  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage array needs no reset; stale entries are never exposed while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; reset wins over any simultaneous push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_ONE;
      end else if (do_pop && !do_push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/demux1x2_buf.sv
// Buffered 1-to-2 demultiplexer: routes each input word to channel A or B,
// each channel buffered by its own FIFO so one stalled consumer never blocks
// the other. Also counts accepted words per channel.
module demux1x2_buf
  import demux1x2_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic a_empty;
  logic a_full;
  logic b_empty;
  logic b_full;
  logic accept;
  logic push_a;
  logic push_b;
  logic pop_a;
  logic pop_b;
  channel_e dest;

  // in_ready looks only at the selected FIFO's registered fullness, so it
  // has no combinational path from either consumer's ready.
  assign dest     = channel_e'(in_sel);
  assign in_ready = (dest == CH_B) ? ~b_full : ~a_full;
  assign accept   = in_valid & in_ready;
  assign push_a   = accept & (dest == CH_A);
  assign push_b   = accept & (dest == CH_B);

  assign a_valid  = ~a_empty;
  assign b_valid  = ~b_empty;
  assign pop_a    = a_valid & a_ready;
  assign pop_b    = b_valid & b_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .push_data (in_data),
    .pop       (pop_a),
    .head_data (a_data),
    .empty     (a_empty),
    .full      (a_full)
  );

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .push_data (in_data),
    .pop       (pop_b),
    .head_data (b_data),
    .empty     (b_empty),
    .full      (b_full)
  );

  // Per-channel accepted-word counters; wrap silently at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (push_a) begin
        cnt_a <= cnt_a + CNT_ONE;
      end
      if (push_b) begin
        cnt_b <= cnt_b + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_demux1x2_buf.sv
// Scoreboard bench for demux1x2_buf: accepted words are queued per channel,
// and a monitor compares every word the DUT hands out against the queue head.
module tb_demux1x2_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [63:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] cnt_a;
  logic [31:0] cnt_b;

  // Second, narrow-counter instance for the counter wrap case.
  logic       rst4;
  logic [7:0] in_data4;
  logic       in_sel4;
  logic       in_valid4;
  logic       in_ready4;
  logic [7:0] a_data4;
  logic       a_valid4;
  logic [7:0] b_data4;
  logic       b_valid4;
  logic [3:0] cnt_a4;
  logic [3:0] cnt_b4;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux1x2_buf #(.WIDTH(64), .DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  demux1x2_buf #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .in_data(in_data4), .in_sel(in_sel4),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a_data(a_data4), .a_valid(a_valid4), .a_ready(1'b1),
    .b_data(b_data4), .b_valid(b_valid4), .b_ready(1'b1),
    .cnt_a(cnt_a4), .cnt_b(cnt_b4)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Offer one word; record it in the scoreboard at the edge it is accepted.
  task automatic applyStimulus(input logic [63:0] d, input logic s);
    bit done = 1'b0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (s) qb.push_back(d);
        else   qa.push_back(d);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: word %h never accepted", d);
    end
  endtask

  // Reset discards all buffered words, so the scoreboard forgets them too.
  task automatic resetPulse(input int cycles);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_done", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  // Monitor: every handshake on an output must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("[TB] FAIL a_unexpected: got %h expected no word", a_data);
        end else begin
          if (a_data !== qa[0]) begin
            errors++;
            $display("[TB] FAIL a_data: got %h expected %h", a_data, qa[0]);
          end
          void'(qa.pop_front());
        end
      end
      if (b_valid && b_ready) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("[TB] FAIL b_unexpected: got %h expected no word", b_data);
        end else begin
          if (b_data !== qb[0]) begin
            errors++;
            $display("[TB] FAIL b_data: got %h expected %h", b_data, qb[0]);
          end
          void'(qb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc4;
    in_data = '0; in_sel = 1'b0; in_valid = 1'b1;
    a_ready = 1'b0; b_ready = 1'b0;
    rst4 = 1'b1; in_data4 = '0; in_sel4 = 1'b1; in_valid4 = 1'b0;

    // Reset held two cycles with a word on offer.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("reset_a_valid", 64'(a_valid), 64'd0);
    checkOutput("reset_b_valid", 64'(b_valid), 64'd0);
    checkOutput("reset_cnt_a", 64'(cnt_a), 64'd0);
    checkOutput("reset_cnt_b", 64'(cnt_b), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Routing.
    applyStimulus(64'h1111_1111_1111_1111, 1'b0);
    applyStimulus(64'h2222_2222_2222_2222, 1'b1);
    @(negedge clk);
    checkOutput("route_a_data", a_data, 64'h1111_1111_1111_1111);
    checkOutput("route_b_data", b_data, 64'h2222_2222_2222_2222);
    checkOutput("route_cnt_a", 64'(cnt_a), 64'd1);
    checkOutput("route_cnt_b", 64'(cnt_b), 64'd1);
    @(posedge clk);
    #1;

    // Isolation: fill A, B still accepts.
    for (int i = 0; i < 3; i++) applyStimulus(64'hA000 + 64'(i), 1'b0);
    in_sel = 1'b0;
    @(negedge clk);
    checkOutput("iso_ready_sel0", 64'(in_ready), 64'd0);
    #1;
    in_sel = 1'b1;
    #1;
    checkOutput("iso_ready_sel1", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(64'h3333_3333_3333_3333, 1'b1);
    checkOutput("iso_cnt_a", 64'(cnt_a), 64'd4);
    checkOutput("iso_cnt_b", 64'(cnt_b), 64'd2);

    // Full + pop: refused this cycle, accepted the next.
    in_data = 64'hA5A5; in_sel = 1'b0; in_valid = 1'b1; a_ready = 1'b1;
    @(negedge clk);
    checkOutput("full_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    a_ready = 1'b0;
    @(negedge clk);
    checkOutput("after_pop_ready", 64'(in_ready), 64'd1);
    if (in_ready) qa.push_back(64'hA5A5);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("full_cnt_a", 64'(cnt_a), 64'd5);

    // Drain both channels through the monitor.
    a_ready = 1'b1; b_ready = 1'b1;
    waitDrain(30);
    @(negedge clk);
    checkOutput("drained_a_valid", 64'(a_valid), 64'd0);
    checkOutput("drained_b_valid", 64'(b_valid), 64'd0);
    @(posedge clk);
    #1;

    // Streaming through B with pointer wrap.
    resetPulse(1);
    for (int i = 0; i < 10; i++) applyStimulus(64'(i), 1'b1);
    waitDrain(30);
    checkOutput("stream_cnt_b", 64'(cnt_b), 64'd10);

    // Narrow counter wraps: 17 accepted words leave cnt_b at 1.
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    acc4 = 0;
    in_valid4 = 1'b1;
    for (int i = 0; i < 40 && acc4 < 17; i++) begin
      in_data4 = 8'(acc4);
      @(negedge clk);
      if (in_ready4) acc4++;
      @(posedge clk);
      #1;
    end
    in_valid4 = 1'b0;
    checkOutput("wrap4_accepted", 64'(acc4), 64'd17);
    checkOutput("wrap4_cnt_b", 64'(cnt_b4), 64'd1);

    // Mid-operation reset discards buffered A words.
    a_ready = 1'b0; b_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(64'hDEAD_0000 + 64'(i), 1'b0);
    resetPulse(1);
    @(negedge clk);
    checkOutput("midrst_a_valid", 64'(a_valid), 64'd0);
    checkOutput("midrst_cnt_a", 64'(cnt_a), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    a_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("midrst_stays_empty", 64'(a_valid), 64'd0);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
